// File: rtl/pwm16bits_compare_dt.sv
// Complementary PWM gate driver: shadowed duty compare, registered reference and dead-time FSM.
// Optional fault latch (fault_n / fault_clr / fault_latched) when PWM16BITS_COMPARE_DT_FAULT_EN is defined.
module pwm16bits_compare_dt #(
  parameter int DT_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic [15:0]         carrier,
  input  logic [15:0]         count_max,
  input  logic [15:0]         compare,
  input  logic [1:0]          load_mode,
  input  logic [DT_WIDTH-1:0] deadtime,
  input  logic                enable,
`ifdef PWM16BITS_COMPARE_DT_FAULT_EN
  input  logic                fault_n,
  input  logic                fault_clr,
  output logic                fault_latched,
`endif
  output logic                pwm_h,
  output logic                pwm_l,
  output logic                sync_min,
  output logic                sync_max
);

  typedef enum logic [2:0] {S_OFF, S_DT_H, S_H_ON, S_DT_L, S_L_ON} state_t;

  state_t              state_q, state_d;
  logic [DT_WIDTH-1:0] dt_cnt_q, dt_cnt_d;
  logic [15:0]         cmp_act;
  logic                ref_q;
  logic                min_seen, max_seen;
  logic                at_min, at_max;
  logic                force_off, dt_zero, dt_last;

  function automatic logic load_hit(input logic [1:0] mode, input logic mn, input logic mx);
    case (mode)
      2'b00:   load_hit = 1'b1;
      2'b01:   load_hit = mn;
      2'b10:   load_hit = mx;
      default: load_hit = mn | mx;
    endcase
  endfunction

  assign at_min  = (carrier == 16'd0);
  assign at_max  = (carrier == count_max);
  assign dt_zero = (deadtime == '0);
  assign dt_last = (dt_cnt_q <= DT_WIDTH'(1));

`ifdef PWM16BITS_COMPARE_DT_FAULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         fault_latched <= 1'b0;
    else if (!fault_n)  fault_latched <= 1'b1;
    else if (fault_clr) fault_latched <= 1'b0;
  end

  // The latch is still set on the clearing edge, so restart waits one more edge.
  assign force_off = !enable || !fault_n || fault_latched;
`else
  assign force_off = !enable;
`endif

  // Stage 1: shadow compare load and reference comparison
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmp_act <= '0;
      ref_q   <= 1'b0;
    end else if (ce) begin
      ref_q <= (carrier < cmp_act);
      if (load_hit(load_mode, at_min, at_max)) cmp_act <= compare;
    end
  end

  // Stage 2: dead-time state machine driven by the registered reference
  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    if (force_off) begin
      state_d  = S_OFF;
      dt_cnt_d = '0;
    end else if (ce) begin
      case (state_q)
        S_OFF: begin
          dt_cnt_d = deadtime;
          if (ref_q) state_d = dt_zero ? S_H_ON : S_DT_H;
          else       state_d = dt_zero ? S_L_ON : S_DT_L;
        end
        S_L_ON: if (ref_q) begin
          dt_cnt_d = deadtime;
          state_d  = dt_zero ? S_H_ON : S_DT_H;
        end
        S_H_ON: if (!ref_q) begin
          dt_cnt_d = deadtime;
          state_d  = dt_zero ? S_L_ON : S_DT_L;
        end
        S_DT_H: begin
          if (!ref_q) begin
            state_d  = S_L_ON;
            dt_cnt_d = '0;
          end else if (dt_last) begin
            state_d  = S_H_ON;
            dt_cnt_d = '0;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_WIDTH'(1);
          end
        end
        S_DT_L: begin
          if (ref_q) begin
            state_d  = S_H_ON;
            dt_cnt_d = '0;
          end else if (dt_last) begin
            state_d  = S_L_ON;
            dt_cnt_d = '0;
          end else begin
            dt_cnt_d = dt_cnt_q - DT_WIDTH'(1);
          end
        end
        default: begin
          state_d  = S_OFF;
          dt_cnt_d = '0;
        end
      endcase
    end
  end

  // Stage 3: state and registered gate outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      dt_cnt_q <= '0;
      pwm_h    <= 1'b0;
      pwm_l    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dt_cnt_q <= dt_cnt_d;
      pwm_h    <= (state_d == S_H_ON);
      pwm_l    <= (state_d == S_L_ON);
    end
  end

  // Carrier sync pulses fire only on the first ce cycle of an equality run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_min <= 1'b0;
      sync_max <= 1'b0;
      min_seen <= 1'b0;
      max_seen <= 1'b0;
    end else if (ce) begin
      sync_min <= at_min & ~min_seen;
      sync_max <= at_max & ~max_seen & (count_max != 16'd0);
      min_seen <= at_min;
      max_seen <= at_max;
    end else begin
      sync_min <= 1'b0;
      sync_max <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm16bits_compare_dt.sv
// Directed bench for pwm16bits_compare_dt: behavioural duty/dead-time model checked every cycle plus literal pins.
module tb_pwm16bits_compare_dt;

  localparam int DTW = 10;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ce = 1'b1;
  logic [15:0]    carrier = 16'd0;
  logic [15:0]    count_max = 16'd99;
  logic [15:0]    compare = 16'd40;
  logic [1:0]     load_mode = 2'b00;
  logic [DTW-1:0] deadtime = '0;
  logic           enable = 1'b0;
  logic           pwm_h, pwm_l, sync_min, sync_max;
`ifdef PWM16BITS_COMPARE_DT_FAULT_EN
  logic           fault_n = 1'b1;
  logic           fault_clr = 1'b0;
  logic           fault_latched;
`endif

  pwm16bits_compare_dt #(.DT_WIDTH(DTW)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .carrier(carrier), .count_max(count_max),
    .compare(compare), .load_mode(load_mode), .deadtime(deadtime), .enable(enable),
`ifdef PWM16BITS_COMPARE_DT_FAULT_EN
    .fault_n(fault_n), .fault_clr(fault_clr), .fault_latched(fault_latched),
`endif
    .pwm_h(pwm_h), .pwm_l(pwm_l), .sync_min(sync_min), .sync_max(sync_max)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit timer_run = 1'b0;
  int cnt_h, cnt_l, cnt_smin, cnt_smax;

  // Behavioural model: which side is wanted, whether running, remaining gap cycles.
  bit          m_run, m_tgt, m_ref, m_h, m_l, m_smin, m_smax, m_flt;
  int          m_gap;
  logic [15:0] m_cmp, m_pc, m_pmax;
  bit          m_pvalid;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_tgt = 0; m_ref = 0; m_h = 0; m_l = 0; m_smin = 0; m_smax = 0;
    m_flt = 0; m_gap = 0; m_cmp = '0; m_pc = '0; m_pmax = '0; m_pvalid = 0;
  endtask

  task automatic model_edge();
    bit blocked;
    bit load;
    if (!rst_n) begin
      model_reset();
      return;
    end
    blocked = !enable;
`ifdef PWM16BITS_COMPARE_DT_FAULT_EN
    blocked = blocked || !fault_n || m_flt;
    if (!fault_n) m_flt = 1;
    else if (fault_clr) m_flt = 0;
`endif
    if (blocked) begin
      m_run = 0;
      m_gap = 0;
    end else if (ce) begin
      if (!m_run) begin
        m_run = 1; m_tgt = m_ref; m_gap = int'(deadtime);
      end else if (m_gap != 0) begin
        if (m_ref != m_tgt) begin m_tgt = m_ref; m_gap = 0; end
        else m_gap--;
      end else if (m_ref != m_tgt) begin
        m_tgt = m_ref; m_gap = int'(deadtime);
      end
    end
    if (ce) begin
      m_smin = (carrier == 0) && !(m_pvalid && m_pc == 0);
      m_smax = (carrier == count_max) && (count_max != 0) && !(m_pvalid && m_pc == m_pmax);
      m_pvalid = 1; m_pc = carrier; m_pmax = count_max;
      case (load_mode)
        2'b00:   load = 1;
        2'b01:   load = (carrier == 0);
        2'b10:   load = (carrier == count_max);
        default: load = (carrier == 0) || (carrier == count_max);
      endcase
      m_ref = (carrier < m_cmp);
      if (load) m_cmp = compare;
    end else begin
      m_smin = 0;
      m_smax = 0;
    end
    m_h = m_run && (m_gap == 0) && m_tgt;
    m_l = m_run && (m_gap == 0) && !m_tgt;
  endtask

  task automatic check_all();
    check("pwm_h", int'(pwm_h), int'(m_h));
    check("pwm_l", int'(pwm_l), int'(m_l));
    check("sync_min", int'(sync_min), int'(m_smin));
    check("sync_max", int'(sync_max), int'(m_smax));
    check("no_overlap", int'(pwm_h & pwm_l), 0);
`ifdef PWM16BITS_COMPARE_DT_FAULT_EN
    check("fault_latched", int'(fault_latched), int'(m_flt));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
    cnt_h += int'(pwm_h); cnt_l += int'(pwm_l);
    cnt_smin += int'(sync_min); cnt_smax += int'(sync_max);
    if (timer_run) carrier = (carrier >= count_max) ? 16'd0 : carrier + 16'd1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic measure(input int n);
    cnt_h = 0; cnt_l = 0; cnt_smin = 0; cnt_smax = 0;
    run(n);
  endtask

  task automatic wait_carrier(input logic [15:0] v);
    int guard = 0;
    while (carrier != v && guard < 400) begin
      step();
      guard++;
    end
    check("wait_carrier", int'(carrier), int'(v));
  endtask

  initial begin
    model_reset();
    run(3);
    check("reset_h", int'(pwm_h), 0);
    check("reset_l", int'(pwm_l), 0);
    check("reset_sync", int'(sync_min | sync_max), 0);

    // 40% duty, no dead time
    rst_n = 1'b1; enable = 1'b1; timer_run = 1'b1;
    run(300);
    measure(100);
    check("duty40_h", cnt_h, 40);
    check("duty40_l", cnt_l, 60);
    check("duty40_smin", cnt_smin, 1);
    check("duty40_smax", cnt_smax, 1);
    wait_carrier(16'd40);
    step();
    check("lat_h_at40", int'(pwm_h), 1);
    step();
    check("lat_h_at41", int'(pwm_h), 0);
    check("lat_l_at41", int'(pwm_l), 1);

    // dead time 5
    deadtime = 10'd5;
    run(200);
    measure(100);
    check("dt5_h", cnt_h, 35);
    check("dt5_l", cnt_l, 55);

    // shadow load at carrier==0
    deadtime = '0; load_mode = 2'b01;
    run(150);
    wait_carrier(16'd50);
    compare = 16'd70;
    cnt_h = 0;
    while (carrier != 16'd0) step();
    check("shadow_hold_h", cnt_h, 0);
    run(150);
    measure(100);
    check("duty70_h", cnt_h, 70);
    check("duty70_l", cnt_l, 30);

    // compare extremes
    load_mode = 2'b00; compare = 16'd0;
    run(5);
    measure(100);
    check("cmp0_l", cnt_l, 100);
    check("cmp0_h", cnt_h, 0);
    compare = 16'd200;
    run(5);
    measure(100);
    check("cmp200_h", cnt_h, 100);

    // reference reversal inside the dead-time gap
    timer_run = 1'b0; carrier = 16'd50; compare = 16'd0; deadtime = 10'd3;
    run(10);
    check("gap_pre_l", int'(pwm_l), 1);
    compare = 16'd100;
    run(3);
    check("gap_entry", int'(pwm_h | pwm_l), 0);
    compare = 16'd0;
    measure(10);
    check("gap_return_h", cnt_h, 0);
    check("gap_return_l", cnt_l, 8);

    // enable drop and dead-time restart
    timer_run = 1'b1; compare = 16'd40; deadtime = '0;
    wait_carrier(16'd20);
    step();
    check("en_pre_h", int'(pwm_h), 1);
    enable = 1'b0;
    step();
    check("en_off", int'(pwm_h | pwm_l), 0);
    run(2);
    timer_run = 1'b0; carrier = 16'd50; compare = 16'd200; deadtime = 10'd4;
    run(3);
    enable = 1'b1;
    measure(4);
    check("restart_gap", cnt_h + cnt_l, 0);
    step();
    check("restart_h", int'(pwm_h), 1);

    // asynchronous reset mid-pulse
    timer_run = 1'b1; compare = 16'd40; deadtime = '0;
    wait_carrier(16'd20);
    step();
    check("rst_pre_h", int'(pwm_h), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_h", int'(pwm_h), 0);
    check("rst_async_l", int'(pwm_l), 0);
    run(2);
    rst_n = 1'b1;
    run(150);

    // clock enable gating
    for (int i = 0; i < 240; i++) begin
      ce = (i % 3) != 0;
      deadtime = (i < 120) ? 10'd2 : 10'd0;
      step();
    end
    ce = 1'b1;
    run(20);

    // count_max == 0 gives sync_min only
    timer_run = 1'b0; carrier = 16'd7; count_max = 16'd0;
    run(2);
    carrier = 16'd0;
    measure(20);
    check("cm0_smin", cnt_smin, 1);
    check("cm0_smax", cnt_smax, 0);

`ifdef PWM16BITS_COMPARE_DT_FAULT_EN
    count_max = 16'd99; timer_run = 1'b1; compare = 16'd40; deadtime = 10'd2;
    run(150);
    wait_carrier(16'd20);
    fault_n = 1'b0; fault_clr = 1'b1;
    step();
    check("fault_off", int'(pwm_h | pwm_l), 0);
    check("fault_set", int'(fault_latched), 1);
    fault_n = 1'b1; fault_clr = 1'b0;
    run(3);
    check("fault_held", int'(fault_latched), 1);
    fault_clr = 1'b1;
    step();
    check("fault_cleared", int'(fault_latched), 0);
    fault_clr = 1'b0;
    run(150);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm16bits_compare_dt.md
PWM16BITS_COMPARE_DT -- requirements
Module: pwm16bits_compare_dt

Interface
REQ-001 SHALL have parameter DT_WIDTH, default 10, dead-time counter width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ce  input  1  clock enable; FSM, dead-time counter and shadow loads advance only when ce=1.
REQ-005 SHALL have port carrier  input  16  unsigned carrier from the 16-bit PWM timer.
REQ-006 SHALL have port count_max  input  16  timer period value (carrier peak).
REQ-007 SHALL have port compare  input  16  requested duty compare value.
REQ-008 SHALL have port load_mode  input  2  shadow load point: 00 every ce cycle, 01 at carrier==0, 10 at carrier==count_max, 11 at either.
REQ-009 SHALL have port deadtime  input  DT_WIDTH  dead time in ce cycles.
REQ-010 SHALL have port enable  input  1  output enable.
REQ-011 SHALL have port pwm_h  output  1  high-side gate, registered.
REQ-012 SHALL have port pwm_l  output  1  low-side gate, registered.
REQ-013 SHALL have port sync_min  output  1  one-cycle pulse on first ce cycle with carrier==0.
REQ-014 SHALL have port sync_max  output  1  one-cycle pulse on first ce cycle with carrier==count_max.

Function
REQ-015 SHALL hold active compare cmp_act, loaded from compare at a ce edge when load_mode condition holds; new value used from the following cycle.
REQ-016 SHALL register ref_q <= (carrier < cmp_act), unsigned 16-bit, on each ce edge; cmp_act=0 gives ref_q=0 always, cmp_act>count_max gives ref_q=1 always.
REQ-017 SHALL implement states S_OFF, S_DT_H, S_H_ON, S_DT_L, S_L_ON; pwm_h=1 only in S_H_ON, pwm_l=1 only in S_L_ON, both 0 elsewhere.
REQ-018 S_L_ON with ref_q=1 SHALL go to S_DT_H loading counter with deadtime; S_H_ON with ref_q=0 SHALL go to S_DT_L likewise.
REQ-019 S_DT_H/S_DT_L SHALL decrement per ce cycle and enter S_H_ON/S_L_ON when counter reaches 1, giving exactly deadtime ce cycles with both outputs 0.
REQ-020 deadtime=0 SHALL transition S_L_ON->S_H_ON (and S_H_ON->S_L_ON) directly, no gap.
REQ-021 ref_q reversing during S_DT_H SHALL return to S_L_ON; during S_DT_L SHALL return to S_H_ON (never both outputs 1).
REQ-022 Latency: carrier crossing cmp_act at edge n -> ref_q at n, output/state change at n+1 (deadtime=0, ce=1).
REQ-023 enable=0 SHALL force S_OFF at the next clock edge regardless of ce.
REQ-024 S_OFF with enable=1 SHALL go to S_DT_H if ref_q=1, else S_DT_L, loading deadtime (deadtime=0: straight to on-state).
REQ-025 sync_min/sync_max SHALL be registered, asserted one cycle when carrier first equals 0/count_max after differing; count_max=0 asserts sync_min only.
REQ-026 pwm_h and pwm_l SHALL never be 1 in the same cycle under any input sequence.

Reset
REQ-027 rst_n=0 SHALL immediately force S_OFF, pwm_h=0, pwm_l=0, sync_min=0, sync_max=0, ref_q=0, cmp_act=0, counter=0.
REQ-028 After rst_n release, SHALL start via REQ-024 at the first edge with enable=1 and ce=1.

Configuration
REQ-029 Macro PWM16BITS_COMPARE_DT_FAULT_EN SHALL, when defined, add input fault_n (active-low), input fault_clr, output fault_latched.
REQ-030 With macro: fault_n=0 sampled SHALL set fault_latched and force S_OFF at that edge regardless of ce/enable; state stays S_OFF while latched.
REQ-031 With macro: fault_clr=1 with fault_n=1 SHALL clear fault_latched; restart per REQ-024; fault_clr while fault_n=0 SHALL be ignored; reset clears fault_latched.
REQ-032 Without macro: ports absent, behaviour identical to fault never asserted.

Verification
REQ-033 Up-count timer count_max=99, compare=40, deadtime=0, load_mode=00 -> pwm_h high 40 of 100 cycles, pwm_l 60, complement, 1-cycle edge delay.
REQ-034 Same with deadtime=5 -> 5 cycles both low at every edge; pwm_h 35 cycles, pwm_l 55.
REQ-035 load_mode=01, compare changes 40->70 mid-period -> duty stays 40 until carrier==0, then 70.
REQ-036 compare=0 -> pwm_l constant 1; compare=200 with count_max=99 -> pwm_h constant 1; deadtime=3, compare toggled inside gap -> return to previous on-state, never overlap.
REQ-037 enable 1->0 mid-pulse -> both low next edge; enable back with ref_q=1, deadtime=4 -> 4 cycles low then pwm_h; rst_n pulse mid-period -> outputs 0 immediately.
REQ-038 With PWM16BITS_COMPARE_DT_FAULT_EN: fault_n low one cycle -> outputs 0 same edge, fault_latched=1; fault_clr while fault_n=0 ignored; after clear, dead-time restart.
